div8b: RTL and testbench

- Sequential restoring divider: unsigned DVW-bit dividend divided by DRW-bit divisor gives a quotient and a remainder.
- It is the inverse of the shift-add multiplier in the 4-bit ALU datapath.
- It uses the same init/done start-complete handshake as the multiplier, so the ALU select mux can adopt it as a new operation slot.
- One quotient bit is produced per clock.

---
 rtl/div8b.sv | 172 +++++++++++++++++
 tb/tb_div8b.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/div8b.sv
// div8b -- sequential restoring divider, one quotient bit per clock.
//
// Divides an unsigned DVW-bit dividend by an unsigned DRW-bit divisor and
// returns a DVW-bit quotient and a DRW-bit remainder. It uses the same
// init/done start/complete handshake as the shift-add multiplier, so the
// ALU select mux can treat it as one more operation slot.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-low reset
//   init      start request, accepted in IDLE or DONE
//   DV        dividend, captured on the accepted start edge
//   DR        divisor, captured on the accepted start edge
//   Q         quotient (registered)
//   R         remainder (registered)
//   done      result valid, held until the next accepted start
//   zero      Q==0 and R==0, registered with Q/R
//   overflow  divide-by-zero flag, registered with Q/R
module div8b #(
  parameter int DVW = 8,
  parameter int DRW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           init,
  input  logic [DVW-1:0] DV,
  input  logic [DRW-1:0] DR,
  output logic [DVW-1:0] Q,
  output logic [DRW-1:0] R,
  output logic           done,
  output logic           zero,
  output logic           overflow
);

  localparam int CW = $clog2(DVW + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DVW);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [DVW-1:0] dvd_q, dvd_d;   // dividend shift register
  logic [DRW-1:0] dvs_q, dvs_d;   // captured divisor
  // The partial remainder is always below the divisor between steps, so only
  // DRW bits need storing; the extra bit exists only in the trial value.
  logic [DRW-1:0] p_q, p_d;
  logic [DVW-1:0] quo_q, quo_d;   // quotient shift register
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [DVW-1:0] q_q, q_d;
  logic [DRW-1:0] r_q, r_d;
  logic           done_q, done_d;
  logic           zero_q, zero_d;
  logic           ovf_q, ovf_d;

  logic [DRW:0]   t_s;
  logic [DRW:0]   diff_s;
  logic           ge_s;
  logic [DRW:0]   p_next_s;
  logic [DVW-1:0] quo_next_s;

  // One restoring step: trial-subtract the divisor on DRW+1 bits.
  always_comb begin
    t_s        = {p_q, dvd_q[DVW-1]};
    diff_s     = t_s - {1'b0, dvs_q};
    ge_s       = (t_s >= {1'b0, dvs_q});
    p_next_s   = ge_s ? diff_s : t_s;
    quo_next_s = {quo_q[DVW-2:0], ge_s};
  end

  // Next-state and datapath register updates.
  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    p_d     = p_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    done_d  = done_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (init) begin
          // Results hold through the new run; only done drops now.
          dvd_d   = DV;
          dvs_d   = DR;
          p_d     = {DRW{1'b0}};
          quo_d   = {DVW{1'b0}};
          cnt_d   = CNT_FULL;
          done_d  = 1'b0;
          state_d = S_CHECK;
        end else begin
          state_d = state_q;
        end
      end
      S_CHECK: begin
        if (dvs_q == {DRW{1'b0}}) begin
          q_d     = {DVW{1'b1}};
          r_d     = {DRW{1'b0}};
          ovf_d   = 1'b1;
          zero_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        dvd_d = {dvd_q[DVW-2:0], 1'b0};
        p_d   = p_next_s[DRW-1:0];
        quo_d = quo_next_s;
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          q_d     = quo_next_s;
          r_d     = p_next_s[DRW-1:0];
          zero_d  = (quo_next_s == {DVW{1'b0}}) && (p_next_s == {(DRW+1){1'b0}});
          ovf_d   = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_SHIFT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      dvd_q   <= {DVW{1'b0}};
      dvs_q   <= {DRW{1'b0}};
      p_q     <= {DRW{1'b0}};
      quo_q   <= {DVW{1'b0}};
      cnt_q   <= {CW{1'b0}};
      q_q     <= {DVW{1'b0}};
      r_q     <= {DRW{1'b0}};
      done_q  <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      p_q     <= p_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      done_q  <= done_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
    end
  end

  assign Q        = q_q;
  assign R        = r_q;
  assign done     = done_q;
  assign zero     = zero_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_div8b.sv
// tb_div8b -- self-checking bench for div8b.
// A behavioural model (plain / and %, plus a completion countdown) predicts
// the outputs; a negedge process compares every cycle. Directed literal
// expectations pin the model, followed by random runs and a full sweep.
// Edge numbering: inputs are driven just after "edge 0", the DUT samples
// init on edge 1, results appear after edge 10 (edge 2 for DR==0).
module tb_div8b;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       init = 1'b0;
  logic [7:0] DV = 8'd0;
  logic [3:0] DR = 4'd0;
  logic [7:0] Q;
  logic [3:0] R;
  logic       done, zero, overflow;

  int errors = 0;
  int checks = 0;

  div8b #(.DVW(8), .DRW(4)) dut (
    .clk(clk), .rst(rst), .init(init), .DV(DV), .DR(DR),
    .Q(Q), .R(R), .done(done), .zero(zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: captured operands plus edges remaining to completion.
  logic [7:0] m_q = 8'd0, m_dv = 8'd0;
  logic [3:0] m_r = 4'd0, m_dr = 4'd0;
  logic       m_done = 1'b0, m_zero = 1'b0, m_ovf = 1'b0;
  int         m_busy = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q = 8'd0; m_r = 4'd0; m_done = 1'b0; m_zero = 1'b0; m_ovf = 1'b0;
      m_busy = 0; m_dv = 8'd0; m_dr = 4'd0;
    end else if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin
        if (m_dr == 4'd0) begin
          m_q = 8'hFF; m_r = 4'd0; m_ovf = 1'b1; m_zero = 1'b0;
        end else begin
          m_q = 8'(int'(m_dv) / int'(m_dr));
          m_r = 4'(int'(m_dv) % int'(m_dr));
          m_ovf = 1'b0;
          m_zero = (m_q == 8'd0) && (m_r == 4'd0);
        end
        m_done = 1'b1;
      end
    end else if (init) begin
      m_dv = DV; m_dr = DR; m_done = 1'b0;
      m_busy = (DR == 4'd0) ? 1 : 9;
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    check("cyc_Q", Q, m_q);
    check("cyc_R", R, m_r);
    check("cyc_done", done, m_done);
    check("cyc_zero", zero, m_zero);
    check("cyc_overflow", overflow, m_ovf);
  end

  // Start one operation from just after an edge and wait for done.
  task automatic run_op(input logic [7:0] dv, input logic [3:0] dr,
                        input int pulse_edge, input bit sweep);
    int n;
    DV = dv; DR = dr; init = 1'b1;
    @(posedge clk); #1;
    n = 1;
    init = 1'b0;
    check("done_drop", done, 0);
    DV = 8'($urandom); DR = 4'($urandom);
    while (!done && n < 20) begin
      if (n + 1 == pulse_edge) begin
        init = 1'b1; DV = 8'd50;
      end else begin
        init = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    init = 1'b0;
    check("latency", n, (dr == 4'd0) ? 2 : 10);
    if (sweep && dr != 4'd0) begin
      check("invariant", int'(Q) * int'(dr) + int'(R), int'(dv));
      check("r_lt_dr", int'(R < dr), 1);
    end
  endtask

  initial begin
    #1 rst = 1'b0;
    #2;
    check("rst_Q", Q, 0); check("rst_R", R, 0); check("rst_done", done, 0);
    check("rst_zero", zero, 0); check("rst_ovf", overflow, 0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;

    run_op(8'd200, 4'd7, 0, 1'b0);
    check("q_200_7", Q, 28); check("r_200_7", R, 4);
    check("zero_200_7", zero, 0); check("ovf_200_7", overflow, 0);
    repeat (3) @(posedge clk);
    #1;
    check("hold_q", Q, 28); check("hold_done", done, 1);

    run_op(8'hFF, 4'd1, 0, 1'b0);
    check("q_ff_1", Q, 255); check("r_ff_1", R, 0);
    run_op(8'd5, 4'd15, 0, 1'b0);
    check("q_5_15", Q, 0); check("r_5_15", R, 5); check("zero_5_15", zero, 0);
    run_op(8'd0, 4'd9, 0, 1'b0);
    check("q_0_9", Q, 0); check("zero_0_9", zero, 1); check("ovf_0_9", overflow, 0);
    run_op(8'd77, 4'd0, 0, 1'b0);
    check("q_div0", Q, 255); check("r_div0", R, 0); check("ovf_div0", overflow, 1);
    check("zero_div0", zero, 0);

    run_op(8'd100, 4'd3, 4, 1'b0);
    check("q_100_3", Q, 33); check("r_100_3", R, 1);
    run_op(8'd50, 4'd3, 0, 1'b0);
    check("q_50_3", Q, 16); check("r_50_3", R, 2);

    // Asynchronous reset in the middle of a division.
    DV = 8'd200; DR = 4'd7; init = 1'b1;
    @(posedge clk); #1 init = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("arst_Q", Q, 0); check("arst_R", R, 0); check("arst_done", done, 0);
    check("arst_zero", zero, 0); check("arst_ovf", overflow, 0);
    #2 rst = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("idle_after_rst", done, 0);

    // Randomised operations, divisor zero included.
    for (int i = 0; i < 200; i++) begin
      run_op(8'($urandom), 4'($urandom_range(0, 15)), 0, 1'b1);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    // init held high: restart on every arrival in DONE.
    init = 1'b1;
    for (int i = 0; i < 60; i++) begin
      DV = 8'($urandom); DR = 4'($urandom_range(0, 15));
      @(posedge clk); #1;
    end
    init = 1'b0;
    repeat (12) @(posedge clk);
    #1;

    // Exhaustive sweep of every non-zero divisor.
    for (int dv = 0; dv < 256; dv++) begin
      for (int dr = 1; dr < 16; dr++) begin
        run_op(8'(dv), 4'(dr), 0, 1'b1);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
